mu_dsync_filter: RTL and testbench

//   Multi-channel synchroniser for asynchronous inputs (buttons, sensor IRQ/ready pins).

---
 rtl/mu_dsync_filter_pkg.sv | 28 ++
 rtl/mu_dsync_filter_ch.sv | 105 ++++++++++
 rtl/mu_dsync_filter.sv | 77 +++++++
 tb/tb_mu_dsync_filter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mu_dsync_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mu_sync_pkg                                                      |
// | Purpose : Shared constants and helpers for the multi-channel input         |
// |           synchroniser / glitch filter (mu_dsync_filter).                  |
// | Contents: sync_min_stages - smallest legal synchroniser chain depth        |
// |           cnt_width()     - width of the per-channel stability counter     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mu_sync_pkg;

  // Two flops is the shortest chain that gives a metastable first stage a
  // full clock period to resolve before anything downstream looks at it.
  localparam int sync_min_stages = 2;

  // The counter holds 0..FILTER-1, so $clog2(FILTER+1) bits always suffice.
  // Clamped to one bit so FILTER == 1 still yields a legal vector.
  function automatic int cnt_width(input int filter);
    int w;
    w = (filter < 1) ? 1 : $clog2(filter + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : mu_sync_pkg
`default_nettype wire

// File: rtl/mu_dsync_filter_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mu_dsync_filter_ch                                               |
// | Purpose : One channel of the input synchroniser: STAGES-deep sync chain,   |
// |           FILTER-cycle stability filter and registered rise/fall strobes.  |
// | Ports   : clk       in   destination clock (posedge)                       |
// |           rst       in   synchronous reset, active-high                    |
// |           din_i     in   asynchronous input                                |
// |           dout_o    out  synchronised, filtered level                      |
// |           rise_o    out  one-cycle strobe, dout_o went 0->1                |
// |           fall_o    out  one-cycle strobe, dout_o went 1->0                |
// |           chg_d_o   out  next-cycle strobe (rise|fall next state), lets    |
// |                          the parent register an aligned OR of all channels |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mu_dsync_filter_ch
  import mu_sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter int   FILTER    = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_d_o
);

  localparam int                 c_cnt_w   = cnt_width(FILTER);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER - 1);

  // --------------------------------------------------------------------------
  // Synchroniser chain. Pure flop-to-flop; the first stage is the only place
  // din_i is sampled.
  // --------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
    end
  end

  logic sync_s;
  assign sync_s = sync_q[STAGES-1];

  // --------------------------------------------------------------------------
  // Stability filter. The counter measures how many consecutive cycles the
  // synchronised level has disagreed with the output; the new level is taken
  // on the FILTER-th such cycle. Any agreement clears the count, so short
  // glitches never reach dout_o. The counter cannot exceed c_cnt_max because
  // reaching it always results in acceptance and a clear.
  // --------------------------------------------------------------------------
  logic               dout_q, dout_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;

  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_s != dout_q) begin
      if (cnt_q == c_cnt_max) begin
        dout_d = sync_s;
        cnt_d  = '0;
        rise_d = sync_s;
        fall_d = ~sync_s;
      end else begin
        cnt_d = cnt_q + c_cnt_w'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Reset wins over any pending acceptance, and never produces a strobe
  // even when it moves dout_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= RESET_VAL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout_o  = dout_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign chg_d_o = rise_d | fall_d;

endmodule : mu_dsync_filter_ch
`default_nettype wire

// File: rtl/mu_dsync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mu_dsync_filter                                                  |
// | Purpose : WIDTH-channel synchroniser for asynchronous chip-edge inputs,    |
// |           with per-channel glitch filtering and registered edge strobes.   |
// | Ports   : clk         in   1      destination clock (posedge)             |
// |           rst         in   1      synchronous reset, active-high          |
// |           din         in   WIDTH  asynchronous inputs                     |
// |           dout        out  WIDTH  synchronised, filtered levels           |
// |           rise        out  WIDTH  one-cycle strobe per channel, 0->1      |
// |           fall        out  WIDTH  one-cycle strobe per channel, 1->0      |
// |           any_change  out  1      OR of all strobes, same cycle           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mu_dsync_filter
  import mu_sync_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  // Illegal configurations stop elaboration rather than building something
  // that silently misbehaves.
  if (WIDTH < 1) begin : g_chk_width
    $error("mu_dsync_filter: WIDTH must be >= 1");
  end
  if (STAGES < sync_min_stages) begin : g_chk_stages
    $error("mu_dsync_filter: STAGES must be >= 2");
  end
  if (FILTER < 1) begin : g_chk_filter
    $error("mu_dsync_filter: FILTER must be >= 1");
  end

  logic [WIDTH-1:0] chg_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    mu_dsync_filter_ch #(
      .STAGES    (STAGES),
      .FILTER    (FILTER),
      .RESET_VAL (RESET_VAL[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .din_i   (din[i]),
      .dout_o  (dout[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i]),
      .chg_d_o (chg_d[i])
    );
  end

  // Built from the channels' next-state strobes so the flop lands in the
  // same cycle as rise/fall rather than one behind.
  logic any_change_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |chg_d;
    end
  end

  assign any_change = any_change_q;

endmodule : mu_dsync_filter
`default_nettype wire

// File: tb/tb_mu_dsync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mu_dsync_filter                                               |
// | Purpose : Self-checking bench for mu_dsync_filter. Three instances cover   |
// |           reset value / simultaneous channels (STAGES=2, FILTER=1),        |
// |           latency / glitch rejection / random traffic (STAGES=3,FILTER=4)  |
// |           and reset in the middle of a long filter (FILTER=8).             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mu_dsync_filter;

  localparam int BW = 4;
  localparam int BS = 3;
  localparam int BF = 4;
  localparam int HLEN = BS + BF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, STAGES=2, FILTER=1, RESET_VAL=1010
  logic       rst_a = 1'b1;
  logic [3:0] din_a = 4'b0101;
  logic [3:0] dout_a, rise_a, fall_a;
  logic       any_a;

  mu_dsync_filter #(.WIDTH(4), .STAGES(2), .FILTER(1), .RESET_VAL(4'b1010)) u_dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .dout(dout_a),
    .rise(rise_a), .fall(fall_a), .any_change(any_a)
  );

  // Instance B: WIDTH=4, STAGES=3, FILTER=4, RESET_VAL=0
  logic       rst_b = 1'b1;
  logic [3:0] din_b = 4'b0000;
  logic [3:0] dout_b, rise_b, fall_b;
  logic       any_b;

  mu_dsync_filter #(.WIDTH(BW), .STAGES(BS), .FILTER(BF), .RESET_VAL(4'b0000)) u_dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .dout(dout_b),
    .rise(rise_b), .fall(fall_b), .any_change(any_b)
  );

  // Instance C: WIDTH=2, STAGES=2, FILTER=8, RESET_VAL=0
  logic       rst_c = 1'b1;
  logic [1:0] din_c = 2'b00;
  logic [1:0] dout_c, rise_c, fall_c;
  logic       any_c;

  mu_dsync_filter #(.WIDTH(2), .STAGES(2), .FILTER(8), .RESET_VAL(2'b00)) u_dut_c (
    .clk(clk), .rst(rst_c), .din(din_c), .dout(dout_c),
    .rise(rise_c), .fall(fall_c), .any_change(any_c)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for instance B. hist[ch][j] is din[ch] as sampled j edges ago
  // (j=0 is this edge). A level is accepted when the FILTER samples that
  // have just emerged from the STAGES-deep chain all differ from the output.
  bit         hist [BW][HLEN];
  logic [3:0] m_dout, m_rise, m_fall;

  task automatic model_step(input logic r, input logic [3:0] d);
    bool_loop: for (int ch = 0; ch < BW; ch++) begin
      if (r) begin
        for (int j = 0; j < HLEN; j++) hist[ch][j] = 1'b0;
        m_dout[ch] = 1'b0;
        m_rise[ch] = 1'b0;
        m_fall[ch] = 1'b0;
      end else begin
        bit all_diff;
        for (int j = HLEN - 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
        hist[ch][0] = d[ch];
        all_diff = 1'b1;
        for (int j = BS; j < BS + BF; j++) begin
          if (hist[ch][j] == m_dout[ch]) all_diff = 1'b0;
        end
        m_rise[ch] = all_diff & ~m_dout[ch];
        m_fall[ch] = all_diff &  m_dout[ch];
        if (all_diff) m_dout[ch] = ~m_dout[ch];
      end
    end
  endtask

  initial begin
    int nrise;
    int cyc;
    int last_evt [BW];

    // ---------------- Reset on instance A ----------------
    rst_a = 1'b1;
    din_a = 4'b0101;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("rst_dout", 32'(dout_a), 32'h0000000a);
      chk("rst_strb", 32'({rise_a, fall_a, any_a}), 32'd0);
    end
    rst_a = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e < 3) begin
        chk("rel_dout", 32'(dout_a), 32'h0000000a);
        chk("rel_strb", 32'({rise_a, fall_a, any_a}), 32'd0);
      end else if (e == 3) begin
        chk("rel_dout3", 32'(dout_a), 32'h00000005);
        chk("rel_rise3", 32'(rise_a), 32'h00000005);
        chk("rel_fall3", 32'(fall_a), 32'h0000000a);
        chk("rel_any3", 32'(any_a), 32'd1);
      end else begin
        chk("rel_strb4", 32'({rise_a, fall_a, any_a}), 32'd0);
        chk("rel_dout4", 32'(dout_a), 32'h00000005);
      end
    end

    // ---------------- Simultaneous channels on A ----------------
    din_a = 4'b0000;
    for (int e = 0; e < 5; e++) tick();
    chk("sim_pre", 32'(dout_a), 32'd0);
    din_a = 4'b1111;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) begin
        chk("sim_rise", 32'(rise_a), 32'h0000000f);
        chk("sim_fall", 32'(fall_a), 32'd0);
        chk("sim_any", 32'(any_a), 32'd1);
        chk("sim_dout", 32'(dout_a), 32'h0000000f);
      end else begin
        chk("sim_quiet", 32'({rise_a, fall_a, any_a}), 32'd0);
      end
    end

    // ---------------- Latency on B (STAGES=3, FILTER=4) ----------------
    din_b = 4'b0000;
    rst_b = 1'b1;
    tick();
    tick();
    rst_b = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    din_b = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e < 7) begin
        chk("lat_wait", 32'({dout_b, rise_b, any_b}), 32'd0);
      end else if (e == 7) begin
        chk("lat_dout", 32'(dout_b), 32'd1);
        chk("lat_rise", 32'(rise_b), 32'd1);
        chk("lat_fall", 32'(fall_b), 32'd0);
        chk("lat_any", 32'(any_b), 32'd1);
      end else begin
        chk("lat_after", 32'({rise_b, any_b}), 32'd0);
      end
    end

    // ---------------- Glitch reject on B ----------------
    din_b = 4'b0000;
    for (int e = 0; e < 10; e++) tick();
    chk("gl_pre", 32'(dout_b), 32'd0);
    nrise = 0;
    din_b[0] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 3) din_b[0] = 1'b0;
      nrise += int'(rise_b[0]);
      chk("gl3_dout", 32'(dout_b[0]), 32'd0);
    end
    chk("gl3_rise", 32'(nrise), 32'd0);
    nrise = 0;
    din_b[0] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 4) din_b[0] = 1'b0;
      nrise += int'(rise_b[0]);
      if (e == 7) begin
        chk("gl4_dout", 32'(dout_b[0]), 32'd1);
        chk("gl4_rise", 32'(rise_b[0]), 32'd1);
      end
    end
    chk("gl4_nrise", 32'(nrise), 32'd1);

    // ---------------- Reset mid-filter on C (FILTER=8) ----------------
    din_c = 2'b00;
    rst_c = 1'b1;
    tick();
    tick();
    rst_c = 1'b0;
    for (int e = 0; e < 4; e++) tick();
    chk("mf_pre", 32'(dout_c), 32'd0);
    din_c = 2'b01;
    // Sampled at edge 1, first seen by the filter at edge 3; edge 7 is the
    // fifth mismatch cycle and is where reset is applied.
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) rst_c = 1'b1;
      chk("mf_cnt", 32'({dout_c, rise_c, fall_c, any_c}), 32'd0);
    end
    rst_c = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e < 10) begin
        chk("mf_wait", 32'({dout_c, rise_c, any_c}), 32'd0);
      end else begin
        chk("mf_dout", 32'(dout_c), 32'd1);
        chk("mf_rise", 32'(rise_c), 32'd1);
        chk("mf_any", 32'(any_c), 32'd1);
      end
    end

    // ---------------- Random traffic on B against the model ----------------
    rst_b = 1'b1;
    din_b = 4'($urandom);
    cyc = 0;
    for (int ch = 0; ch < BW; ch++) last_evt[ch] = -1000;
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk);
      model_step(rst_b, din_b);
      if (rst_b) begin
        for (int ch = 0; ch < BW; ch++) last_evt[ch] = -1000;
      end
      #1;
      cyc++;
      chk("rnd_dout", 32'(dout_b), 32'(m_dout));
      chk("rnd_rise", 32'(rise_b), 32'(m_rise));
      chk("rnd_fall", 32'(fall_b), 32'(m_fall));
      chk("rnd_any", 32'(any_b), 32'(|(m_rise | m_fall)));
      chk("rnd_excl", 32'(rise_b & fall_b), 32'd0);
      for (int ch = 0; ch < BW; ch++) begin
        if (rise_b[ch] | fall_b[ch]) begin
          chk("rnd_space", 32'((cyc - last_evt[ch]) >= BF), 32'd1);
          last_evt[ch] = cyc;
        end
      end
      rst_b = ($urandom_range(0, 999) == 0);
      #($urandom_range(0, 7));
      for (int ch = 0; ch < BW; ch++) begin
        if ($urandom_range(0, 3) == 0) din_b[ch] = ~din_b[ch];
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mu_dsync_filter
`default_nettype wire
